// File: rtl/fft_frame_rx_if.sv
// fft_frame_rx_if: streaming output bundle of the FFT core.
// The core drives the beat; the receiver drives source_ready back.
interface fft_frame_rx_if #(
   parameter int DATA_W = 12,
   parameter int EXP_W  = 6
);
   logic                     source_valid;
   logic                     source_ready;
   logic                     source_sop;
   logic                     source_eop;
   logic [1:0]               source_error;
   logic [EXP_W-1:0]         source_exp;
   logic signed [DATA_W-1:0] source_real;
   logic signed [DATA_W-1:0] source_imag;

   modport master (
      output source_valid,
      output source_sop,
      output source_eop,
      output source_error,
      output source_exp,
      output source_real,
      output source_imag,
      input  source_ready
   );

   modport slave (
      input  source_valid,
      input  source_sop,
      input  source_eop,
      input  source_error,
      input  source_exp,
      input  source_real,
      input  source_imag,
      output source_ready
   );
endinterface

// File: rtl/fft_frame_rx.sv
// fft_frame_rx: stores per-bin power of an FFT frame and tracks its peak.
// Option FFT_RX_SKIP_DC_EN: bin 0 is kept out of the peak search.
module fft_frame_rx #(
   parameter int DATA_W = 12,
   parameter int EXP_W  = 6,
   parameter int FFT_N  = 1024,
   parameter int ADDR_W = 10,
   parameter int AMP_W  = 25
)(
   input  logic              sys_clk,
   input  logic              sys_rst,
   fft_frame_rx_if.slave     src,
   output logic [AMP_W-1:0]  amp,
   output logic              amp_valid,
   output logic [ADDR_W-1:0] amp_idx,
   output logic              frame_done,
   output logic              frame_err,
   output logic [ADDR_W-1:0] peak_idx,
   output logic [AMP_W-1:0]  peak_amp,
   output logic [EXP_W-1:0]  frame_exp,
   input  logic              frame_ack,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [AMP_W-1:0]  rd_data
);

   localparam int PW = 2*DATA_W-1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FFT_N-1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic              w_ready;
   logic              w_acc;
   logic              w_take;
   logic              w_sop_take;
   logic              w_last;
   logic              w_bad;
   logic              w_fin;
   logic [ADDR_W-1:0] w_cnt;
   logic [ADDR_W-1:0] r_cnt;

   logic signed [PW-1:0] w_re_x;
   logic signed [PW-1:0] w_im_x;
   logic signed [PW-1:0] w_re2;
   logic signed [PW-1:0] w_im2;
   logic [PW-1:0]        r_re2;
   logic [PW-1:0]        r_im2;
   logic                 r_s1_vld;
   logic                 r_s1_last;
   logic [ADDR_W-1:0]    r_s1_idx;
   logic [AMP_W-1:0]     w_sum;
   logic                 w_pk_load;

   logic [AMP_W-1:0] r_ram [FFT_N];

   // Beat qualification
   assign w_acc      = src.source_valid & w_ready;
   assign w_take     = w_acc & (src.source_sop | (r_state == S_RECV));
   assign w_sop_take = w_take & src.source_sop;
   assign w_cnt      = src.source_sop ? '0 : r_cnt;
   assign w_last     = (w_cnt == LAST);
   assign w_bad      = w_take & ((|src.source_error)
                              | (src.source_eop ^ w_last));
   assign w_fin      = w_take & ~w_bad & src.source_eop;

   // FSM: state register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM: next state
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_RECV: begin
            if (w_bad) begin
               w_next = S_IDLE;
            end else if (w_fin) begin
               w_next = S_DONE;
            end else if (w_take) begin
               w_next = S_RECV;
            end
         end
         S_DONE: begin
            if (frame_ack) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_ready = 1'b1;
      if (r_state == S_DONE) begin
         w_ready = 1'b0;
      end
   end

   assign src.source_ready = w_ready;

   // Squares fit PW bits unsigned: worst case (-2^(DATA_W-1))^2
   assign w_re_x = {{(PW-DATA_W){src.source_real[DATA_W-1]}},
                    src.source_real};
   assign w_im_x = {{(PW-DATA_W){src.source_imag[DATA_W-1]}},
                    src.source_imag};
   assign w_re2  = w_re_x * w_re_x;
   assign w_im2  = w_im_x * w_im_x;
   assign w_sum  = AMP_W'(r_re2) + AMP_W'(r_im2);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_s1_vld   <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_idx   <= '0;
         r_re2      <= '0;
         r_im2      <= '0;
         amp_valid  <= 1'b0;
         amp        <= '0;
         amp_idx    <= '0;
         frame_done <= 1'b0;
      end else begin
         r_s1_vld   <= w_take;
         r_s1_last  <= w_fin;
         amp_valid  <= r_s1_vld;
         frame_done <= r_s1_vld & r_s1_last;
         if (w_take) begin
            r_re2    <= w_re2;
            r_im2    <= w_im2;
            r_s1_idx <= w_cnt;
         end
         if (r_s1_vld) begin
            amp     <= w_sum;
            amp_idx <= r_s1_idx;
         end
      end
   end

`ifdef FFT_RX_SKIP_DC_EN
   assign w_pk_load = r_s1_vld
                    & ((r_s1_idx == ADDR_W'(1))
                    | ((r_s1_idx != '0) & (w_sum > peak_amp)));
`else
   assign w_pk_load = r_s1_vld
                    & ((r_s1_idx == '0) | (w_sum > peak_amp));
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt     <= '0;
         frame_exp <= '0;
         frame_err <= 1'b0;
         peak_idx  <= '0;
         peak_amp  <= '0;
      end else begin
         if (w_take) begin
            r_cnt <= w_cnt + ADDR_W'(1);
         end
         if (w_sop_take) begin
            frame_exp <= src.source_exp;
         end
         if (w_bad) begin
            frame_err <= 1'b1;
         end else if (w_sop_take) begin
            frame_err <= 1'b0;
         end
         // A new sop wins over a late update from the old frame
         if (w_sop_take) begin
            peak_idx <= '0;
            peak_amp <= '0;
         end else if (w_pk_load) begin
            peak_idx <= r_s1_idx;
            peak_amp <= w_sum;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (r_s1_vld) begin
         r_ram[r_s1_idx] <= w_sum;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= r_ram[rd_addr];
      end
   end

endmodule

// File: tb/tb_fft_frame_rx.sv
// tb_fft_frame_rx: directed frames against a transaction-level model.
// Checks amp stream, handshake, errors, peak and buffer reads.
module tb_fft_frame_rx;

   localparam int DW = 12;
   localparam int EW = 6;
   localparam int N  = 16;
   localparam int AW = 4;
   localparam int PW = 25;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW-1:0] amp;
   logic          amp_valid;
   logic [AW-1:0] amp_idx;
   logic          frame_done;
   logic          frame_err;
   logic [AW-1:0] peak_idx;
   logic [PW-1:0] peak_amp;
   logic [EW-1:0] frame_exp;
   logic          frame_ack;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_data;

   always #5 clk = ~clk;

   fft_frame_rx_if #(.DATA_W(DW), .EXP_W(EW)) src ();

   fft_frame_rx #(
      .DATA_W(DW), .EXP_W(EW), .FFT_N(N), .ADDR_W(AW), .AMP_W(PW)
   ) u_dut (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .src        (src),
      .amp        (amp),
      .amp_valid  (amp_valid),
      .amp_idx    (amp_idx),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .peak_idx   (peak_idx),
      .peak_amp   (peak_amp),
      .frame_exp  (frame_exp),
      .frame_ack  (frame_ack),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: frame-level view (0 idle, 1 in frame, 2 holding frame)
   typedef struct {
      int due;
      int a;
      int i;
   } ev_t;

   ev_t q[$];
   int  cyc        = 0;
   int  m_st       = 0;
   int  m_cnt      = 0;
   int  m_err      = 0;
   int  m_done_due = -1;
   int  m_pk_i     = 0;
   int  m_pk_a     = 0;
   int  m_exp      = 0;
   int  m_fexp     = 0;
   int  n_done     = 0;
   int  fpow [N];
   bit  cmp_en     = 1'b0;
   int  t_idx;
   int  t_p;
   int  t_r;
   int  t_i;
   bit  t_take;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         m_st       = 0;
         m_cnt      = 0;
         m_err      = 0;
         m_done_due = -1;
      end else begin
         t_take = src.source_valid && (m_st != 2)
               && (src.source_sop || m_st == 1);
         if (m_st == 2 && frame_ack) m_st = 0;
         if (t_take) begin
            t_idx = src.source_sop ? 0 : m_cnt;
            t_r   = $signed(src.source_real);
            t_i   = $signed(src.source_imag);
            t_p   = t_r*t_r + t_i*t_i;
            q.push_back(ev_t'{cyc+1, t_p, t_idx});
            fpow[t_idx] = t_p;
            m_cnt = t_idx + 1;
            if (src.source_sop) begin
               m_exp = int'(src.source_exp);
               m_err = 0;
            end
            if (src.source_error != 0
                || (src.source_eop != (t_idx == N-1))) begin
               m_err = 1;
               m_st  = 0;
            end else if (src.source_eop) begin
               m_st       = 2;
               m_done_due = cyc + 1;
               m_fexp     = m_exp;
               m_pk_i     = -1;
               for (int b = 0; b < N; b++) begin
`ifdef FFT_RX_SKIP_DC_EN
                  if (b == 0) continue;
`endif
                  if (m_pk_i < 0 || fpow[b] > m_pk_a) begin
                     m_pk_i = b;
                     m_pk_a = fpow[b];
                  end
               end
            end else begin
               m_st = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ready", src.source_ready, m_st != 2);
         chk("frame_err", frame_err, m_err);
         if (q.size() > 0 && q[0].due == cyc) begin
            chk("amp_valid", amp_valid, 1);
            chk("amp", amp, q[0].a);
            chk("amp_idx", amp_idx, q[0].i);
            void'(q.pop_front());
         end else begin
            chk("amp_valid_idle", amp_valid, 0);
         end
         chk("frame_done", frame_done, cyc == m_done_due);
         if (frame_done) n_done++;
         if (cyc == m_done_due) begin
            chk("peak_idx_m", peak_idx, m_pk_i);
            chk("peak_amp_m", peak_amp, m_pk_a);
            chk("frame_exp_m", frame_exp, m_fexp);
         end
      end
   end

   int fre [N];
   int fim [N];
   int nd0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(bit sop, bit eop, int re, int im, int er, int ex);
      src.source_valid = 1'b1;
      src.source_sop   = sop;
      src.source_eop   = eop;
      src.source_error = 2'(er);
      src.source_exp   = EW'(ex);
      src.source_real  = DW'(re);
      src.source_imag  = DW'(im);
      step();
      src.source_valid = 1'b0;
      src.source_sop   = 1'b0;
      src.source_eop   = 1'b0;
      src.source_error = 2'b00;
   endtask

   task automatic send(int nb, int eop_at, int ex, int err_at);
      for (int i = 0; i < nb; i++) begin
         beat(i == 0, i == eop_at, fre[i], fim[i],
              (i == err_at) ? 1 : 0, ex);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < N; i++) begin
         fre[i] = 0;
         fim[i] = 0;
      end
   endtask

   task automatic ack();
      frame_ack = 1'b1;
      step();
      frame_ack = 1'b0;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_ready"}, src.source_ready, 1);
      chk({tag, "_amp_valid"}, amp_valid, 0);
      chk({tag, "_amp"}, amp, 0);
      chk({tag, "_amp_idx"}, amp_idx, 0);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_err"}, frame_err, 0);
      chk({tag, "_peak_idx"}, peak_idx, 0);
      chk({tag, "_peak_amp"}, peak_amp, 0);
      chk({tag, "_exp"}, frame_exp, 0);
      chk({tag, "_rd_data"}, rd_data, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      src.source_valid = 1'b0;
      src.source_sop   = 1'b0;
      src.source_eop   = 1'b0;
      src.source_error = 2'b00;
      src.source_exp   = '0;
      src.source_real  = '0;
      src.source_imag  = '0;
      frame_ack        = 1'b0;
      rd_addr          = '0;
      repeat (3) step();
      chk_zero("rst");
      rst    = 1'b0;
      cmp_en = 1'b1;
      step();

      // Ramp frame: amp = idx^2
      for (int i = 0; i < N; i++) begin
         fre[i] = i;
         fim[i] = 0;
      end
      nd0 = n_done;
      send(16, 15, 5, -1);
      step();
      step();
      chk("t1_ndone", n_done - nd0, 1);
      chk("t1_peak_idx", peak_idx, 15);
      chk("t1_peak_amp", peak_amp, 225);
      chk("t1_exp", frame_exp, 5);
      chk("t1_ready", src.source_ready, 0);
      rd_addr = 4'd7;
      step();
      chk("t1_rd7", rd_data, 49);
      rd_addr = 4'd3;
      step();
      chk("t1_rd3", rd_data, 9);
      beat(1, 0, 99, 0, 0, 1);
      step();
      step();
      chk("t1_hold_amp", peak_amp, 225);
      chk("t1_hold_exp", frame_exp, 5);
      ack();
      chk("t1_ready_ack", src.source_ready, 1);

      // Tie between bins 3 and 9
      clr();
      fre[3] = -100;
      fim[3] = 50;
      fre[9] = -100;
      fim[9] = 50;
      send(16, 15, 2, -1);
      step();
      step();
      chk("t2_peak_idx", peak_idx, 3);
      chk("t2_peak_amp", peak_amp, 12500);
      ack();

      // Full-scale negative input
      clr();
      fre[2] = -2048;
      fim[2] = -2048;
      fre[7] = 2047;
      fim[7] = 2047;
      send(16, 15, 1, -1);
      step();
      step();
      chk("t2b_peak_idx", peak_idx, 2);
      chk("t2b_peak_amp", peak_amp, 8388608);
      rd_addr = 4'd7;
      step();
      chk("t2b_rd7", rd_data, 8380418);
      ack();

      // Early eop aborts, next frame recovers
      for (int i = 0; i < N; i++) fre[i] = i;
      nd0 = n_done;
      send(11, 10, 4, -1);
      step();
      step();
      chk("t3_err", frame_err, 1);
      chk("t3_ndone", n_done - nd0, 0);
      chk("t3_ready", src.source_ready, 1);
      send(16, 15, 6, -1);
      step();
      step();
      chk("t3_err_clr", frame_err, 0);
      chk("t3_ndone2", n_done - nd0, 1);
      chk("t3_exp", frame_exp, 6);
      ack();

      // Restart on second sop
      clr();
      for (int i = 0; i < N; i++) fre[i] = 40;
      nd0 = n_done;
      send(6, -1, 7, -1);
      for (int i = 0; i < N; i++) begin
         fre[i] = 0;
         fim[i] = 2*i;
      end
      send(16, 15, 9, -1);
      step();
      step();
      chk("t4_ndone", n_done - nd0, 1);
      chk("t4_exp", frame_exp, 9);
      chk("t4_peak_idx", peak_idx, 15);
      chk("t4_peak_amp", peak_amp, 900);
      ack();

      // DC bin dominance
      clr();
      fre[0] = 1000;
      fre[4] = 30;
      send(16, 15, 3, -1);
      step();
      step();
`ifdef FFT_RX_SKIP_DC_EN
      chk("t5_peak_idx", peak_idx, 4);
      chk("t5_peak_amp", peak_amp, 900);
`else
      chk("t5_peak_idx", peak_idx, 0);
      chk("t5_peak_amp", peak_amp, 1000000);
`endif
      ack();

      // Core error on beat 5
      for (int i = 0; i < N; i++) fre[i] = i;
      nd0 = n_done;
      send(16, -1, 1, 5);
      step();
      step();
      chk("t6_err", frame_err, 1);
      chk("t6_ndone", n_done - nd0, 0);
      chk("t6_ready", src.source_ready, 1);

      // Reset in the middle of a frame
      send(8, -1, 3, -1);
      src.source_valid = 1'b1;
      src.source_real  = DW'(8);
      rst = 1'b1;
      step();
      chk_zero("t7");
      rst = 1'b0;
      src.source_valid = 1'b0;
      repeat (4) step();
      chk("t7_ndone", n_done - nd0, 0);
      chk("t7_qempty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_frame_rx.md
Name: fft_frame_rx

Overview:
- Consumes the streaming output of the FFT core: source_valid/sop/eop/real/imag/exp.
- Drives source_ready back to the core.
- Per accepted bin: computes power re²+im² and writes it into an internal frame buffer.
- Tracks the peak bin of each frame; holds the completed frame for a downstream reader until acknowledged.

Parameters:
- DATA_W, 12, width of signed FFT real/imag outputs
- EXP_W, 6, width of block-floating exponent
- FFT_N, 1024, bins per frame (power of two)
- ADDR_W, 10, log2(FFT_N)
- AMP_W, 25, power width (2*DATA_W+1)

Ports:
- sys_clk  in  1  single clock, the FFT core clock
- sys_rst  in  1  synchronous, active-high reset
- source_valid  in  1  FFT output beat valid
- source_ready  out  1  block can accept a beat
- source_sop  in  1  first bin of frame
- source_eop  in  1  last bin of frame
- source_error  in  2  core error code; nonzero = bad beat
- source_exp  in  EXP_W  block exponent, sampled on sop beat
- source_real  in  DATA_W  signed real part
- source_imag  in  DATA_W  signed imaginary part
- amp  out  AMP_W  power of most recent bin
- amp_valid  out  1  amp/amp_idx valid this cycle
- amp_idx  out  ADDR_W  bin index of amp
- frame_done  out  1  one-cycle pulse: full frame stored
- frame_err  out  1  sticky: last frame aborted
- peak_idx  out  ADDR_W  bin of maximum power in held frame
- peak_amp  out  AMP_W  maximum power value
- frame_exp  out  EXP_W  exponent of held frame
- frame_ack  in  1  reader finished; release buffer
- rd_addr  in  ADDR_W  buffer read address
- rd_data  out  AMP_W  buffer read data, 1-cycle latency

Behaviour:
- Beat accepted when source_valid & source_ready.
- States:
  - IDLE: source_ready=1; wait for an accepted beat with sop.
  - RECV: source_ready=1; collecting bins.
  - DONE: source_ready=0; buffer frozen.
- Reset values: state IDLE; all outputs 0 except source_ready=1. RAM contents are not cleared.
- IDLE: accepted beats without sop are dropped.
- Accepted sop beat in IDLE or RECV:
  - bin counter=0; frame_exp<=source_exp; peak cleared (peak_amp=0, peak_idx=0).
  - frame_err cleared; state RECV.
  - sop in RECV restarts the frame; the partial frame is discarded and no frame_done is issued.
- Each accepted beat in RECV (including the sop beat) enters the pipeline with idx=counter; counter increments.
- Pipeline:
  - Stage 1 registers re*re and im*im, each 2*DATA_W-1 bits unsigned.
  - Stage 2 registers their zero-extended sum to AMP_W, writes RAM[idx], and drives amp/amp_idx/amp_valid.
  - Latency: accepted beat -> amp_valid = 2 cycles.
  - Example: re=-2048, im=-2048 -> amp=8388608, no overflow.
- Peak update in stage 2:
  - Update if amp > peak_amp (strict compare), so the lowest index wins ties.
  - idx 0 always loads the peak.
- Frame completes on an accepted eop beat with counter==FFT_N-1.
  - State goes to DONE immediately, so source_ready=0 from the next cycle.
  - frame_done pulses in the cycle after that bin's stage-2 write, so peak and RAM are final.
- Error aborts (frame_err<=1, state IDLE, no frame_done, pipeline writes still complete):
  - eop with counter!=FFT_N-1;
  - counter reaches FFT_N-1 without eop;
  - any accepted beat with source_error!=0.
- DONE:
  - frame_ack -> IDLE next cycle; source_ready=1 the cycle after ack.
  - frame_ack in other states is ignored.
- While in DONE: peak_idx, peak_amp and frame_exp are held stable until the next sop.
- Read port:
  - rd_data = RAM[rd_addr] registered, available in all states.
  - Read-during-write to the same address returns the old data.
- Reset asserted mid-frame: state to IDLE, pipeline valids cleared, frame_done is not generated.

Optional Feature:
- Macro FFT_RX_SKIP_DC_EN.
- Defined: bin 0 is excluded from the peak search. Peak is initialised by bin 1 and only bins 1..FFT_N-1 compete. Bin 0 is still written to RAM and shown on amp.
- Undefined: all bins compete, as described in Behaviour.

Test Plan:
- Bench runs with FFT_N=16, ADDR_W=4.
- Frame: sop, 16 beats re=idx, im=0, eop on beat 15 -> amp_valid 2 cycles after each beat with amp=idx²; frame_done once; peak_idx=15, peak_amp=225; source_ready=0 until frame_ack; rd_addr=7 -> rd_data=49 next cycle.
- Bins 3 and 9 both re=-100, im=50, all other bins 0 -> peak_idx=3, peak_amp=12500.
- eop on beat 10 -> frame_err=1, no frame_done, state IDLE. Next good frame -> frame_err=0 on its sop, frame_done on completion.
- Second sop at beat 6, then 16 good beats -> a single frame_done. Values match the second frame. frame_exp equals the exponent on the second sop.
- Bin 0 re=1000, bin 4 re=30, others 0:
  - FFT_RX_SKIP_DC_EN undefined -> peak_idx=0.
  - FFT_RX_SKIP_DC_EN defined -> peak_idx=4, peak_amp=900.
- source_error=2'b01 on beat 5 -> abort with frame_err=1. Separately, sys_rst at beat 8 -> source_ready=1 and all outputs 0 next cycle, no frame_done.
